// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared constants and helpers for the 7-segment display path.
//           Segment patterns are active-high, bit6..bit0 = g,f,e,d,c,b,a.
// Contents: SEG_0..SEG_F, SEG_DASH, SEG_OFF patterns; segment bit indices;
//           calc_div() per-digit dwell computation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Segment bit positions inside a 7-bit pattern
    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    // Active-high glyph patterns
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h7C;
    localparam logic [6:0] SEG_C    = 7'h39;
    localparam logic [6:0] SEG_D    = 7'h5E;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_F    = 7'h71;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Clock cycles spent on each digit before the scan advances
    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module  : seg7_hex_decode
// Purpose : Combinational 4-bit code to active-high 7-segment pattern.
//           Codes 10..15 render as A,b,C,d,E,F when HEX_MODE != 0, else as
//           a dash.
// Ports   : code [3:0] in  - digit code
//           seg  [6:0] out - active-high pattern, bit6..bit0 = g..a
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    localparam bit c_hex = (HEX_MODE != 0);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = c_hex ? SEG_A : SEG_DASH;
            4'hB:    seg = c_hex ? SEG_B : SEG_DASH;
            4'hC:    seg = c_hex ? SEG_C : SEG_DASH;
            4'hD:    seg = c_hex ? SEG_D : SEG_DASH;
            4'hE:    seg = c_hex ? SEG_E : SEG_DASH;
            default: seg = c_hex ? SEG_F : SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module  : seg7_scan_driver
// Purpose : Time-multiplexed N-digit common-anode 7-segment driver. Latches
//           a packed digit word into a shadow register on load, scans one
//           digit per DIV = CLK_HZ/SCAN_HZ cycles, blanks all anodes for
//           BLANK_CYCLES after each digit change, and supports leading-zero
//           blanking. Outputs are registered (one cycle behind the state).
// Macro   : SEG7_BLINK_EN - adds a blink phase that hides blink_mask digits
//           for alternate CLK_HZ/(2*BLINK_HZ)-cycle periods.
// Ports   : clk                in  - system clock
//           reset_n            in  - synchronous active-low reset
//           bcd_in[4N-1:0]     in  - packed digits, digit 0 = [3:0], rightmost
//           load               in  - capture bcd_in into the shadow register
//           digit_en[N-1:0]    in  - per-digit enable (0 = dark)
//           lzb                in  - leading-zero blanking enable
//           blink_mask[N-1:0]  in  - digits that blink (SEG7_BLINK_EN only)
//           seg_n[6:0]         out - active-low segments g..a
//           an_n[N-1:0]        out - active-low anodes, one-hot-low or all 1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0,
    parameter int BLINK_HZ     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int c_div   = calc_div(CLK_HZ, SCAN_HZ);
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_blk_w = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_blk_w-1:0]    c_blk_init = c_blk_w'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] c_an_one   = NUM_DIGITS'(1);

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [c_div_w-1:0]      r_div;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_blk_w-1:0]      r_blank;
    logic [6:0]              r_seg_n;
    logic [NUM_DIGITS-1:0]   r_an_n;

    logic [3:0]              w_code;
    logic                    w_dig_en;
    logic                    w_lzb_hide;
    logic                    w_blink_hide;
    logic [NUM_DIGITS-1:0]   w_lzb_vec;
    logic [6:0]              w_pattern;
    logic [6:0]              w_seg_n;
    logic [NUM_DIGITS-1:0]   w_an_n;

    // ------------------------------------------------------------------
    // Scan timing and shadow capture. Reset takes priority over load, and
    // the output registers are forced dark so no partial digit survives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow <= '0;
            r_div    <= '0;
            r_idx    <= '0;
            r_blank  <= c_blk_init;
            r_seg_n  <= ~SEG_OFF;
            r_an_n   <= '1;
        end else begin
            if (load) begin
                r_shadow <= bcd_in;
            end
            if (r_div == c_div_last) begin
                r_div   <= '0;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                r_blank <= c_blk_init;
            end else begin
                r_div <= r_div + 1'b1;
                if (r_blank != '0) begin
                    r_blank <= r_blank - 1'b1;
                end
            end
            r_seg_n <= w_seg_n;
            r_an_n  <= w_an_n;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero map: walk from the most significant digit down, keeping
    // a running "everything so far is zero" flag. Disabled digits count as
    // zero. Digit 0 is never blanked so an all-zero word still shows "0".
    // ------------------------------------------------------------------
    always_comb begin : lzb_map
        logic zero_run;
        zero_run  = 1'b1;
        w_lzb_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & ((r_shadow[4*k +: 4] & {4{digit_en[k]}}) == 4'h0);
            if (k != 0) begin
                w_lzb_vec[k] = lzb & zero_run;
            end
        end
    end

    // Active-digit selection
    always_comb begin
        w_code     = 4'h0;
        w_dig_en   = 1'b0;
        w_lzb_hide = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_code     = r_shadow[4*k +: 4];
                w_dig_en   = digit_en[k];
                w_lzb_hide = w_lzb_vec[k];
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int c_blink_half = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_bcnt_w     = (c_blink_half > 1) ? $clog2(c_blink_half) : 1;
    localparam logic [c_bcnt_w-1:0] c_bcnt_last = c_bcnt_w'(c_blink_half - 1);

    logic [c_bcnt_w-1:0] r_blink_cnt;
    logic                r_blink_phase;
    logic                w_blink_sel;

    // Phase 0 = visible; flips each half blink period
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_bcnt_last) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_blink_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_blink_sel = blink_mask[k];
            end
        end
    end

    assign w_blink_hide = r_blink_phase & w_blink_sel;
`else
    localparam int c_unused_blink_hz = BLINK_HZ;
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink_hide   = 1'b0;
`endif

    seg7_hex_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .code (w_code),
        .seg  (w_pattern)
    );

    // Next output value: dark during anti-ghost blanking or when suppressed
    always_comb begin
        w_seg_n = ~SEG_OFF;
        w_an_n  = '1;
        if ((r_blank == '0) && w_dig_en && !w_lzb_hide && !w_blink_hide) begin
            w_seg_n = ~w_pattern;
            w_an_n  = ~(c_an_one << r_idx);
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module  : tb_seg7_scan_driver
// Purpose : Self-checking bench for seg7_scan_driver (NUM_DIGITS=4,
//           CLK_HZ=1000, SCAN_HZ=100 -> 10 cycles per digit). Two instances
//           share inputs: one decimal/dash (HEX_MODE=0), one hex (HEX_MODE=1).
//           A frame-position model predicts every output cycle; directed
//           literal checks pin key values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;
    localparam int HALF  = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        lzb = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [6:0]  seg_dec, seg_hex;
    logic [3:0]  an_dec, an_hex;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_t = 0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100),
        .BLANK_CYCLES(2), .HEX_MODE(0), .BLINK_HZ(1)
    ) dut_dec (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .digit_en(digit_en), .lzb(lzb), .blink_mask(blink_mask),
        .seg_n(seg_dec), .an_n(an_dec)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(100),
        .BLANK_CYCLES(2), .HEX_MODE(1), .BLINK_HZ(1)
    ) dut_hex (
        .clk(clk), .reset_n(reset_n), .bcd_in(bcd_in), .load(load),
        .digit_en(digit_en), .lzb(lzb), .blink_mask(blink_mask),
        .seg_n(seg_hex), .an_n(an_hex)
    );

    function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
        case (c)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return hex ? 7'h77 : 7'h40;
            4'hB: return hex ? 7'h7C : 7'h40;
            4'hC: return hex ? 7'h39 : 7'h40;
            4'hD: return hex ? 7'h5E : 7'h40;
            4'hE: return hex ? 7'h79 : 7'h40;
            default: return hex ? 7'h71 : 7'h40;
        endcase
    endfunction

    // Digit d is hidden by lzb when the value formed by digits d and above
    // (disabled digits zeroed) is zero.
    function automatic bit lzb_hidden(input logic [15:0] w, input logic [3:0] en,
                                      input int d, input bit lz);
        logic [15:0] m;
        m = 16'h0;
        for (int k = 0; k < N; k++) if (en[k]) m[4*k +: 4] = w[4*k +: 4];
        return lz && (d > 0) && ((m >> (4 * d)) == 16'h0);
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle model and compare
    always @(posedge clk) begin : model
        logic [6:0]  e0, e1;
        logic [3:0]  ea;
        logic [15:0] din;
        bit          r, ld, vis;
        int          p, d, o;
        r   = !reset_n;
        ld  = load;
        din = bcd_in;
        e0  = 7'h7F; e1 = 7'h7F; ea = 4'hF;
        if (!r) begin
            p   = m_t % FRAME;
            d   = p / DIV;
            o   = p % DIV;
            vis = (o >= BLANK) && digit_en[d] && !lzb_hidden(m_shadow, digit_en, d, lzb);
`ifdef SEG7_BLINK_EN
            if ((((m_t / HALF) % 2) == 1) && blink_mask[d]) vis = 1'b0;
`endif
            if (vis) begin
                e0 = ~glyph(m_shadow[4*d +: 4], 1'b0);
                e1 = ~glyph(m_shadow[4*d +: 4], 1'b1);
                ea = ~(4'b0001 << d);
            end
        end
        #1;
        if (r || m_valid) begin
            chk("model_seg_dec", seg_dec, e0);
            chk("model_an_dec", {3'b0, an_dec}, {3'b0, ea});
            chk("model_seg_hex", seg_hex, e1);
            chk("model_an_hex", {3'b0, an_hex}, {3'b0, ea});
        end
        if (r) begin
            m_t = 0; m_shadow = 16'h0; m_valid = 1'b1;
        end else begin
            m_t++;
            if (ld) m_shadow = din;
        end
    end

    task automatic wait_pos(input int d, input int o, input string nm);
        int g;
        g = 0;
        while ((m_t % FRAME) != d * DIV + o) begin
            @(negedge clk);
            g++;
            if (g > 2 * FRAME) begin
                total++; bad++;
                $display("FAIL %s timeout waiting for slot %0d.%0d", nm, d, o);
                return;
            end
        end
    endtask

    // Wait until the state is at digit d offset o, then check the registered output
    task automatic lit_at(input int d, input int o, input logic [6:0] s0,
                          input logic [6:0] s1, input logic [3:0] a, input string nm);
        wait_pos(d, o, nm);
        @(negedge clk);
        chk({nm, "_seg_dec"}, seg_dec, s0);
        chk({nm, "_seg_hex"}, seg_hex, s1);
        chk({nm, "_an"}, {3'b0, an_dec}, {3'b0, a});
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, with a load attempt that must be ignored
        repeat (2) @(negedge clk);
        bcd_in = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("reset_seg", seg_dec, 7'h7F);
        chk("reset_an", {3'b0, an_dec}, 7'h0F);
        reset_n = 1'b1;
        lit_at(0, 5, ~7'h3F, ~7'h3F, 4'b1110, "reset_shadow_zero");

        // basic decimal word
        do_load(16'h1234);
        lit_at(0, 5, ~7'h66, ~7'h66, 4'b1110, "d0_4");
        lit_at(3, 2, ~7'h06, ~7'h06, 4'b0111, "d3_first_lit");
        lit_at(0, 1, 7'h7F, 7'h7F, 4'hF, "blank_slot");
        lit_at(1, 9, ~7'h4F, ~7'h4F, 4'b1101, "d1_last_lit");

        // leading-zero blanking
        lzb = 1'b1;
        do_load(16'h0007);
        lit_at(2, 5, 7'h7F, 7'h7F, 4'hF, "lzb_d2_dark");
        lit_at(0, 5, ~7'h07, ~7'h07, 4'b1110, "lzb_d0_7");
        do_load(16'h0000);
        lit_at(1, 5, 7'h7F, 7'h7F, 4'hF, "lzb_zero_d1_dark");
        lit_at(0, 5, ~7'h3F, ~7'h3F, 4'b1110, "lzb_zero_d0");

        // disabled digit counts as zero for lzb
        digit_en = 4'b0111;
        do_load(16'h1007);
        lit_at(2, 5, 7'h7F, 7'h7F, 4'hF, "en_lzb_d2_dark");
        lzb = 1'b0;
        lit_at(2, 5, ~7'h3F, ~7'h3F, 4'b1011, "en_nolzb_d2");
        lit_at(3, 5, 7'h7F, 7'h7F, 4'hF, "en_d3_dark");
        digit_en = 4'hF;

        // hex vs dash
        do_load(16'hAB00);
        lit_at(3, 5, ~7'h40, ~7'h77, 4'b0111, "hex_A");
        lit_at(2, 5, ~7'h40, ~7'h7C, 4'b1011, "hex_B");

        // mid-frame load
        do_load(16'h1111);
        wait_pos(1, 4, "midload");
        bcd_in = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("midload_old", seg_dec, ~7'h06);
        @(negedge clk);
        chk("midload_new", seg_dec, ~7'h5B);
        chk("midload_an", {3'b0, an_dec}, {3'b0, 4'b1101});

        // reset mid-digit
        wait_pos(2, 5, "midreset");
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midreset_seg", seg_dec, 7'h7F);
        chk("midreset_an", {3'b0, an_dec}, 7'h0F);
        lit_at(0, 5, ~7'h3F, ~7'h3F, 4'b1110, "midreset_restart");

        // mixed traffic checked by the model
        for (int i = 0; i < 12; i++) begin
            digit_en = 4'($urandom_range(0, 15));
            lzb = 1'($urandom_range(0, 1));
            do_load(16'($urandom));
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        digit_en = 4'hF; lzb = 1'b0;

`ifdef SEG7_BLINK_EN
        blink_mask = 4'b0001;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        lit_at(0, 5, ~7'h3F, ~7'h3F, 4'b1110, "blink_visible");
        repeat (505) @(negedge clk);
        lit_at(0, 5, 7'h7F, 7'h7F, 4'hF, "blink_hidden");
        lit_at(1, 5, ~7'h3F, ~7'h3F, 4'b1101, "blink_other");
        repeat (520) @(negedge clk);
        blink_mask = 4'h0;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
